// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths and FSM encoding for the UART transmit arbiter
package uart_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 2;
  localparam int ID_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and serializer signals shared by the arbiter
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]        req;
  logic [WORD_W*NREQ-1:0] req_data;
  logic [STRB_W*NREQ-1:0] req_strb;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        err;
  logic [ID_W-1:0]        grant_id;
  logic                   active;
  logic                   u_enable;
  logic [WORD_W-1:0]      u_data_write;
  logic [STRB_W-1:0]      u_s_strobe;
  logic                   u_busy;

  modport master (
    input  req, req_data, req_strb, u_busy,
    output ack, err, grant_id, active, u_enable, u_data_write, u_s_strobe
  );

  modport slave (
    output req, req_data, req_strb, u_busy,
    input  ack, err, grant_id, active, u_enable, u_data_write, u_s_strobe
  );

endinterface

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational round-robin winner select starting after last_i
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] last_i,
  output logic            any_req_o,
  output logic [ID_W-1:0] win_idx_o
);

  // Farthest candidate is scanned first so the nearest one after last_i is written last.
  always_comb begin
    any_req_o = 1'b0;
    win_idx_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_i[i] && (i == (int'(last_i) + k) % NREQ)) begin
          any_req_o = 1'b1;
          win_idx_o = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART word serializer among NREQ requesters
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master arb_if
);

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic              enable_q, enable_d;
  logic              active_q, active_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic              any_req;
  logic [ID_W-1:0]   win_idx;

  uart_rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i     (arb_if.req),
    .last_i    (last_q),
    .any_req_o (any_req),
    .win_idx_o (win_idx)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_d  = grant_q;
    data_d   = data_q;
    strb_d   = strb_q;
    enable_d = enable_q;
    active_d = active_q;
    ack_d    = '0;
    err_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        // A still-running serializer (e.g. across our own reset) must finish first.
        if (any_req && !arb_if.u_busy) begin
          for (int i = 0; i < NREQ; i++) begin
            if (win_idx == ID_W'(i)) begin
              data_d = arb_if.req_data[WORD_W*i +: WORD_W];
              strb_d = arb_if.req_strb[STRB_W*i +: STRB_W];
            end
          end
          grant_d  = win_idx;
          active_d = 1'b1;
          enable_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (arb_if.u_busy) begin
          enable_d = 1'b0;
          state_d  = ST_RUN;
        end else if (cnt_q == TO_W'(TIMEOUT)) begin
          enable_d = 1'b0;
          for (int i = 0; i < NREQ; i++) err_d[i] = (grant_q == ID_W'(i));
          state_d  = ST_ERR;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_RUN: begin
        if (!arb_if.u_busy) begin
          for (int i = 0; i < NREQ; i++) ack_d[i] = (grant_q == ID_W'(i));
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERR: begin
        active_d = 1'b0;
        last_d   = grant_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= ID_W'(NREQ - 1);
      grant_q  <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      enable_q <= 1'b0;
      active_q <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
      enable_q <= enable_d;
      active_q <= active_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign arb_if.ack          = ack_q;
  assign arb_if.err          = err_q;
  assign arb_if.grant_id     = grant_q;
  assign arb_if.active       = active_q;
  assign arb_if.u_enable     = enable_q;
  assign arb_if.u_data_write = data_q;
  assign arb_if.u_s_strobe   = strb_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized bench with a transaction-level round-robin model
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ    = 4;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) arb_if ();

  uart_tx_arbiter #(.NREQ(NREQ), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (arb_if.master)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          last_model = NREQ - 1;
  logic [31:0] word [NREQ];
  logic [1:0]  strb [NREQ];
  int          sdelay = -1;
  int          sleft  = 0;
  bit          dead   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic post(input int i, input logic [31:0] w, input logic [1:0] s);
    word[i] = w;
    strb[i] = s;
    arb_if.req_data[32*i +: 32] = w;
    arb_if.req_strb[2*i +: 2]   = s;
    arb_if.req[i]               = 1'b1;
  endtask

  // Serializer: starts 0..2 cycles after seeing u_enable, stays busy 1..5 cycles.
  task automatic ser_step();
    if (dead) begin
      arb_if.u_busy = 1'b0;
    end else begin
      if (arb_if.u_busy) begin
        sleft--;
        if (sleft == 0) arb_if.u_busy = 1'b0;
      end else if (sdelay < 0 && arb_if.u_enable) begin
        sdelay = $urandom_range(0, 2);
      end
      if (!arb_if.u_busy && sdelay == 0) begin
        arb_if.u_busy = 1'b1;
        sleft  = $urandom_range(1, 5);
        sdelay = -1;
      end else if (sdelay > 0) begin
        sdelay--;
      end
    end
  endtask

  task automatic run_batch(input string name, input logic [NREQ-1:0] mask, input int nxfer,
                           input bit repost, input bit drop, input bit dead_i);
    int done, cyc, exp_win, en_cnt, done_cyc;
    bit prev_en, first;
    logic [NREQ-1:0] oh;
    dead = dead_i; sdelay = -1; sleft = 0; arb_if.u_busy = 1'b0;
    done = 0; cyc = 0; prev_en = 1'b0; first = 1'b1; done_cyc = -10; exp_win = 0; en_cnt = 0;
    for (int i = 0; i < NREQ; i++)
      if (mask[i]) post(i, $urandom, 2'($urandom_range(0, 3)));
    while (done < nxfer && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (arb_if.u_enable && !prev_en) begin
        exp_win = rr_pick(arb_if.req, last_model);
        check({name, "/grant_id"}, 64'(arb_if.grant_id), 64'(exp_win));
        if (exp_win < 0) exp_win = 0;
        check({name, "/data"}, 64'(arb_if.u_data_write), 64'(word[exp_win]));
        check({name, "/strb"}, 64'(arb_if.u_s_strobe), 64'(strb[exp_win]));
        check({name, "/active_at_grant"}, 64'(arb_if.active), 64'd1);
        if (first) check({name, "/first_latency"}, 64'(cyc), 64'd1);
        else       check({name, "/idle_gap"}, 64'(cyc - done_cyc >= 2), 64'd1);
        first = 1'b0;
        en_cnt = 0;
        if (drop) begin
          arb_if.req[exp_win] = 1'b0;
          arb_if.req_data[32*exp_win +: 32] = ~word[exp_win];
        end
      end
      if (arb_if.u_enable) en_cnt++;
      if ((arb_if.ack | arb_if.err) != '0) begin
        oh = NREQ'(1) << exp_win;
        check({name, "/ack"}, 64'(arb_if.ack), dead ? 64'd0 : 64'(oh));
        check({name, "/err"}, 64'(arb_if.err), dead ? 64'(oh) : 64'd0);
        check({name, "/data_held"}, 64'(arb_if.u_data_write), 64'(word[exp_win]));
        if (dead) check({name, "/enable_cycles"}, 64'(en_cnt), 64'(TIMEOUT + 1));
        last_model = exp_win;
        done++;
        done_cyc = cyc;
        if (repost && !drop) post(exp_win, $urandom, 2'($urandom_range(0, 3)));
        else arb_if.req[exp_win] = 1'b0;
      end
      prev_en = arb_if.u_enable;
      ser_step();
    end
    check({name, "/completed"}, 64'(done), 64'(nxfer));
    arb_if.req = '0;
    @(negedge clk);
    check({name, "/idle_after"}, 64'({arb_if.active, arb_if.u_enable, arb_if.ack, arb_if.err}), 64'd0);
    dead = 1'b0;
    arb_if.u_busy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit en_seen;
    logic [NREQ-1:0] mask;
    int nx;
    bit rp;
    rst = 1'b1;
    arb_if.req = '0;
    arb_if.req_data = '0;
    arb_if.req_strb = '0;
    arb_if.u_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("reset/outputs", 64'({arb_if.ack, arb_if.err, arb_if.grant_id, arb_if.active,
          arb_if.u_enable, arb_if.u_data_write, arb_if.u_s_strobe}), 64'd0);
    rst = 1'b0;

    post(0, 32'hAABBCCDD, 2'd3);
    run_batch("t1_single", '0, 1, 1'b0, 1'b0, 1'b0);
    check("t1/last_data", 64'(arb_if.u_data_write), 64'hAABBCCDD);

    post(1, $urandom, 2'd0);
    post(2, $urandom, 2'd0);
    run_batch("t2_pair", '0, 2, 1'b0, 1'b0, 1'b0);
    check("t2/last_grant", 64'(arb_if.grant_id), 64'd2);

    run_batch("t4_timeout", 4'b1000, 1, 1'b0, 1'b0, 1'b1);
    run_batch("t3_all", 4'b1111, 8, 1'b1, 1'b0, 1'b0);
    run_batch("t6_drop", 4'b0100, 1, 1'b0, 1'b1, 1'b0);

    post(0, $urandom, 2'd1);
    en_seen = 1'b0;
    for (int c = 0; c < 10 && !en_seen; c++) begin
      @(negedge clk);
      en_seen = arb_if.u_enable;
    end
    check("t5/launch", 64'(en_seen), 64'd1);
    arb_if.u_busy = 1'b1;
    repeat (2) @(negedge clk);
    check("t5/in_run", 64'({arb_if.active, arb_if.u_enable}), 64'b10);
    rst = 1'b1;
    #1;
    check("t5/reset_clears", 64'({arb_if.ack, arb_if.err, arb_if.grant_id, arb_if.active,
          arb_if.u_enable, arb_if.u_data_write, arb_if.u_s_strobe}), 64'd0);
    last_model = NREQ - 1;
    @(negedge clk);
    rst = 1'b0;
    en_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      en_seen = en_seen | arb_if.u_enable;
    end
    check("t5/blocked_by_busy", 64'(en_seen), 64'd0);
    arb_if.u_busy = 1'b0;
    @(negedge clk);
    check("t5/grant_after_busy", 64'({arb_if.u_enable, arb_if.grant_id}), 64'({1'b1, 3'd0}));
    check("t5/data", 64'(arb_if.u_data_write), 64'(word[0]));
    arb_if.u_busy = 1'b1;
    @(negedge clk);
    arb_if.u_busy = 1'b0;
    @(negedge clk);
    check("t5/ack", 64'({arb_if.ack, arb_if.err}), 64'({4'b0001, 4'b0000}));
    last_model = 0;
    arb_if.req = '0;
    repeat (2) @(negedge clk);

    for (int b = 0; b < 6; b++) begin
      mask = NREQ'($urandom_range(1, 15));
      rp   = 1'($urandom_range(0, 1));
      nx   = rp ? $urandom_range(2, 8) : $countones(mask);
      run_batch($sformatf("rand%0d", b), mask, nx, rp, 1'b0, b == 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
